fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end and the producer side of the decode handshake.
- Owns the architectural PC and issues word reads to instruction memory.
- Presents each fetched word to the decode block on instruction_data / instruction_RDY_BSY, then waits for decode's PC-update outcome (relative offset or absolute jump).
- Applies that outcome to the PC and fetches the next instruction. One instruction is in flight at a time; there is no prefetch.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable  in  1  fetch permission; sampled only in IDLE
- imem_req  out  1  instruction memory read request; level, held until imem_valid
- imem_addr  out  32  read address; equals pc_counter
- imem_rdata  in  32  read data; valid when imem_valid=1
- imem_valid  in  1  read data strobe; minimum latency 1 cycle after imem_req rises
- instruction_data  out  32  fetched instruction to decode
- instruction_RDY_BSY  out  1  1: instruction_data valid and offered; 0: nothing offered
- decoder_rdy_bsy  in  1  decode status; a sampled 0 while offering = accepted
- pc_update  in  1  one-cycle strobe: decode outcome valid
- pc_offset  in  13  signed relative PC offset
- pc_jump_address  in  32  absolute target
- pc_absolute_flag  in  1  1: use pc_jump_address; 0: use pc_offset
- pc_counter  out  32  address of instruction currently being fetched/decoded
- fetch_count  out  32  count of instructions accepted by decode
- misalign_err  out  1  sticky misaligned-target error

Behaviour:
- Reset is synchronous, active-high: rst sampled on the rising edge of clk. It overrides every other input.
- Reset values:
  - pc_counter = imem_addr = RESET_PC.
  - imem_req = 0, instruction_data = 0, instruction_RDY_BSY = 0.
  - fetch_count = 0, misalign_err = 0.
  - state = IDLE.
- States: IDLE, WAIT_MEM, PRESENT, WAIT_UPD, ERROR.
- IDLE:
  - If enable=1: imem_req<=1, imem_addr<=pc_counter, go to WAIT_MEM.
  - Otherwise stay in IDLE.
- WAIT_MEM:
  - imem_req and imem_addr are held.
  - imem_valid is sampled only in this state.
  - On imem_valid=1: instruction_data<=imem_rdata, imem_req<=0, instruction_RDY_BSY<=1, go to PRESENT.
- PRESENT:
  - instruction_data and instruction_RDY_BSY=1 are held stable.
  - On the first cycle with decoder_rdy_bsy=0: instruction_RDY_BSY<=0, fetch_count<=fetch_count+1, go to WAIT_UPD.
  - Any pc_update in this state, including the acceptance cycle, is ignored.
- WAIT_UPD: on pc_update=1, compute next as follows.
  - pc_absolute_flag=1: next = {pc_jump_address[31:1],1'b0}.
  - pc_absolute_flag=0 and pc_offset=0: next = pc_counter+4 (not-taken branch / sequential).
  - Otherwise: next = pc_counter + sign_extend_32(pc_offset).
  - All sums are modulo 2^32; wrap-around is silent.
  - If next[1:0]!=0: misalign_err<=1, pc_counter unchanged, go to ERROR.
  - Else: pc_counter<=next, imem_addr<=next, go to IDLE.
- ERROR:
  - imem_req=0 and instruction_RDY_BSY=0.
  - All inputs are ignored; exit only via rst.
- pc_counter is stable from IDLE exit through WAIT_UPD, so decode can form pc_counter+4 links.
- Minimum loop is 4 cycles per instruction: IDLE, WAIT_MEM (latency 1), PRESENT (immediate accept), WAIT_UPD (immediate update).
- Reset mid-operation abandons the transaction. An imem_valid arriving after reset is ignored because the unit is in IDLE with imem_req=0.
- fetch_count wraps from 0xFFFFFFFF to 0.

Test Plan:
- Basic fetch: RESET_PC=0, enable=1, memory returns 0x00500093 after 1 cycle.
  - Expect imem_addr=0x0 and instruction_RDY_BSY=1 with data 0x00500093.
  - Decoder drops rdy_bsy: instruction_RDY_BSY=0 next cycle, fetch_count=1.
  - pc_update with offset 13'd4: pc_counter=0x4, next imem_addr=0x4.
- Relative and sequential updates:
  - pc_counter=0x100, pc_update with offset 13'h1FF8 (-8) -> pc_counter=0xF8.
  - Offset 0 -> pc_counter=0xFC.
- Absolute jump: pc_absolute_flag=1, pc_jump_address=0x2001 -> pc_counter=0x2000, no error.
- Misaligned target: pc_absolute_flag=1, pc_jump_address=0x2002.
  - Expect misalign_err=1, pc_counter unchanged.
  - imem_req stays 0 for 20 cycles with enable=1.
  - rst clears misalign_err and restores RESET_PC.
- Wrap-around: pc_counter=0xFFFFFFFC, offset 4 -> pc_counter=0x0, next fetch at 0x0.
- Stalls and reset:
  - Memory latency 5, decoder holds rdy_bsy=1 for 3 PRESENT cycles: instruction_data stable throughout.
  - pc_update pulsed during PRESENT is ignored (pc_counter unchanged).
  - rst asserted in WAIT_MEM followed by a late imem_valid: outputs stay at reset values, state IDLE.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port, decode handshake,
// PC-update outcome from decode and the unit's status outputs.
`timescale 1ns/1ps
interface fetch_unit_if;
  logic        enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction_data;
  logic        instruction_RDY_BSY;
  logic        decoder_rdy_bsy;
  logic        pc_update;
  logic [12:0] pc_offset;
  logic [31:0] pc_jump_address;
  logic        pc_absolute_flag;
  logic [31:0] pc_counter;
  logic [31:0] fetch_count;
  logic        misalign_err;

  // Fetch unit side
  modport master (
    input  enable, imem_rdata, imem_valid, decoder_rdy_bsy,
           pc_update, pc_offset, pc_jump_address, pc_absolute_flag,
    output imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
           pc_counter, fetch_count, misalign_err
  );

  // Memory / decode / control side
  modport slave (
    output enable, imem_rdata, imem_valid, decoder_rdy_bsy,
           pc_update, pc_offset, pc_jump_address, pc_absolute_flag,
    input  imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
           pc_counter, fetch_count, misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads one word from instruction
// memory, offers it to decode, then applies decode's PC-update outcome.
// One instruction in flight; no prefetch.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master fu
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_PRESENT,
    S_WAIT_UPD,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_req;
  logic        r_rdy;
  logic        r_err;

  logic [31:0] w_offset_ext;
  logic [31:0] w_next;

  assign w_offset_ext = {{19{fu.pc_offset[12]}}, fu.pc_offset};

  // Next PC from decode's outcome; a zero offset means fall-through (+4)
  always_comb begin
    w_next = r_pc + 32'd4;
    if (fu.pc_absolute_flag) begin
      w_next = fu.pc_jump_address & 32'hFFFF_FFFE;
    end else if (fu.pc_offset != 13'd0) begin
      w_next = r_pc + w_offset_ext;
    end
  end

  // Fetch FSM with registered outputs; the error state is only left via rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_count <= 32'd0;
      r_req   <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fu.enable) begin
            r_req   <= 1'b1;
            r_state <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (fu.imem_valid) begin
            r_instr <= fu.imem_rdata;
            r_req   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // pc_update is deliberately not looked at here
          if (!fu.decoder_rdy_bsy) begin
            r_rdy   <= 1'b0;
            r_count <= r_count + 32'd1;
            r_state <= S_WAIT_UPD;
          end
        end
        S_WAIT_UPD: begin
          if (fu.pc_update) begin
            if (w_next[1:0] != 2'b00) begin
              r_err   <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_pc    <= w_next;
              r_state <= S_IDLE;
            end
          end
        end
        S_ERROR: begin
          r_req <= 1'b0;
          r_rdy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The read address is always the architectural PC
  assign fu.imem_req            = r_req;
  assign fu.imem_addr           = r_pc;
  assign fu.instruction_data    = r_instr;
  assign fu.instruction_RDY_BSY = r_rdy;
  assign fu.pc_counter          = r_pc;
  assign fu.fetch_count         = r_count;
  assign fu.misalign_err        = r_err;

endmodule
